sprite_draw_engine: RTL

Responder side of the move-logic → draw handshake. It accepts a draw request (screen coordinate plus image index) on draw_sprite_start while draw_sprite_rdy is high. It then walks the sprite image ROM pixel by pixel and writes opaque, on-screen pixels into the frame buffer, clipping at the screen edges. It sits between the sprite movement logic (the initiator) and the frame-buffer write port.

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_draw_engine_if.sv | 48 ++++
 rtl/sprite_fb_addr.sv | 19 +
 rtl/sprite_draw_engine.sv | 109 ++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite draw path.
// Used by the draw engine and the frame-buffer address helper.
package sprite_pkg;
  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PIX_W    = 24;
  localparam int FBA_W    = 19;
  localparam int COL_W    = $clog2(SPRITE_W);
  localparam int ROW_W    = $clog2(SPRITE_H);

  localparam logic [PIX_W-1:0] TRANSPARENT = 24'hFF00FF;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [FBA_W-1:0] fba_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE,
    WRITE
  } state_t;
endpackage

// File: rtl/sprite_draw_engine_if.sv
// Draw request, image ROM and frame-buffer signals.
// The engine takes the slave side; the environment the master side.
import sprite_pkg::*;

interface sprite_draw_engine_if;
  logic        draw_sprite_start;
  logic [9:0]  draw_sprite_x;
  logic [8:0]  draw_sprite_y;
  logic [7:0]  draw_sprite_image;
  logic        draw_sprite_rdy;
  logic        rom_re;
  logic [15:0] rom_addr;
  pix_t        rom_data;
  logic        fb_we;
  fba_t        fb_addr;
  pix_t        fb_data;
  logic        fb_stall;

  modport slave (
    input  draw_sprite_start,
    input  draw_sprite_x,
    input  draw_sprite_y,
    input  draw_sprite_image,
    output draw_sprite_rdy,
    output rom_re,
    output rom_addr,
    input  rom_data,
    output fb_we,
    output fb_addr,
    output fb_data,
    input  fb_stall
  );

  modport master (
    output draw_sprite_start,
    output draw_sprite_x,
    output draw_sprite_y,
    output draw_sprite_image,
    input  draw_sprite_rdy,
    input  rom_re,
    input  rom_addr,
    output rom_data,
    input  fb_we,
    input  fb_addr,
    input  fb_data,
    output fb_stall
  );
endinterface

// File: rtl/sprite_fb_addr.sv
// Screen (x,y) to linear frame-buffer address plus on-screen flag.
// y*640 is built from shifts so no multiplier is needed.
import sprite_pkg::*;

module sprite_fb_addr (
  input  logic [10:0] sx_i,
  input  logic [9:0]  sy_i,
  output fba_t        addr_o,
  output logic        on_o
);
  fba_t sx_w;
  fba_t sy_w;

  assign sx_w   = FBA_W'(sx_i);
  assign sy_w   = FBA_W'(sy_i);
  assign addr_o = (sy_w << 9) + (sy_w << 7) + sx_w;
  assign on_o   = (sx_i < 11'(SCREEN_W)) &&
                  (sy_i < 10'(SCREEN_H));
endmodule

// File: rtl/sprite_draw_engine.sv
// Sprite blitter: walks the image ROM and writes opaque,
// on-screen pixels to the frame buffer, 3 cycles per pixel.
import sprite_pkg::*;

module sprite_draw_engine (
  input logic                  clk,
  input logic                  rst_n,
  sprite_draw_engine_if.slave  sp_if
);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(SPRITE_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(SPRITE_H - 1);

  state_t           state_q;
  state_t           state_d;
  logic [9:0]       x_q;
  logic [8:0]       y_q;
  logic [7:0]       img_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  pix_t             pix_q;
  logic [10:0]      sx_q;
  logic [9:0]       sy_q;

  fba_t             fba_w;
  logic             on_w;
  logic             we_w;
  logic             hold_w;
  logic             last_w;

  sprite_fb_addr u_fba (
    .sx_i   (sx_q),
    .sy_i   (sy_q),
    .addr_o (fba_w),
    .on_o   (on_w)
  );

  assign we_w   = (state_q == WRITE) &&
                  (pix_q != TRANSPARENT) && on_w;
  assign hold_w = we_w && sp_if.fb_stall;
  assign last_w = (row_q == ROW_MAX) && (col_q == COL_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sp_if.draw_sprite_start) state_d = FETCH;
      FETCH:   state_d = CAPTURE;
      CAPTURE: state_d = WRITE;
      WRITE: begin
        if (!hold_w) state_d = last_w ? IDLE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and datapath registers
  always_comb begin
    sp_if.draw_sprite_rdy = (state_q == IDLE);
    sp_if.rom_re          = (state_q == FETCH);
    sp_if.rom_addr        = 16'({img_q, row_q, col_q});
    sp_if.fb_we           = we_w;
    sp_if.fb_addr         = fba_w;
    sp_if.fb_data         = pix_q;
  end

  // Request latches, pixel walk and captured pixel/coordinates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      img_q <= '0;
      row_q <= '0;
      col_q <= '0;
      pix_q <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sp_if.draw_sprite_start) begin
            x_q   <= sp_if.draw_sprite_x;
            y_q   <= sp_if.draw_sprite_y;
            img_q <= sp_if.draw_sprite_image;
            row_q <= '0;
            col_q <= '0;
          end
        end
        CAPTURE: begin
          pix_q <= sp_if.rom_data;
          sx_q  <= {1'b0, x_q} + 11'(col_q);
          sy_q  <= {1'b0, y_q} + 10'(row_q);
        end
        WRITE: begin
          if (!hold_w) begin
            col_q <= col_q + 1'b1;
            if (col_q == COL_MAX) row_q <= row_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
